// File: rtl/if_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// if_fetch_unit_if
//   Bundles the buses of the instruction-fetch stage:
//     - instruction memory request/acknowledge port,
//     - control-flow redirect input,
//     - IF/ID valid/ready output towards decode.
//   Modports:
//     master : the fetch unit (drives imem request and IF/ID entry)
//     slave  : the environment (memory, branch unit, decode)
// ----------------------------------------------------------------------------
interface if_fetch_unit_if #(
  parameter int XLEN = 32
);
  // Instruction memory port
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  // Redirect from execute / branch resolution
  logic            redir_valid;
  logic [XLEN-1:0] redir_pc;

  // IF/ID handshake towards decode
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_inst;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc_next;
  logic            id_misaligned;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redir_valid, redir_pc,
    output id_valid, id_inst, id_pc, id_pc_next, id_misaligned,
    input  id_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redir_valid, redir_pc,
    input  id_valid, id_inst, id_pc, id_pc_next, id_misaligned,
    output id_ready
  );
endinterface

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage: PC register, PC incrementer, IF/ID register and a
//   one-entry skid buffer around a variable-latency req/ack memory port.
//   Supports redirects (killing an in-flight fetch), downstream stall through
//   id_valid/id_ready, and trapping of misaligned redirect targets.
//
//   Ports:
//     clk         rising-edge clock
//     pc_reset_n  asynchronous active-low reset
//     pc_enable   when low, no new memory request is started
//     bus         if_fetch_unit_if.master: imem_*, redir_*, id_*
// ----------------------------------------------------------------------------
module if_fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              INST_BYTES = 4
) (
  input  logic               clk,
  input  logic               pc_reset_n,
  input  logic               pc_enable,
  if_fetch_unit_if.master    bus
);

  localparam logic [XLEN-1:0] INC        = XLEN'(INST_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INST_BYTES - 1);
  localparam logic [31:0]     NOP        = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SKID,
    ST_HALT
  } state_e;

  state_e          state_q,         state_d;
  logic [XLEN-1:0] pc_q,            pc_d;
  logic [XLEN-1:0] req_addr_q,      req_addr_d;
  logic            imem_req_q,      imem_req_d;
  logic            kill_q,          kill_d;
  logic            skid_valid_q,    skid_valid_d;
  logic [31:0]     skid_inst_q,     skid_inst_d;
  logic [XLEN-1:0] skid_pc_q,       skid_pc_d;
  logic            id_valid_q,      id_valid_d;
  logic [31:0]     id_inst_q,       id_inst_d;
  logic [XLEN-1:0] id_pc_q,         id_pc_d;
  logic            id_misaligned_q, id_misaligned_d;

  logic ack_live;
  logic bus_busy;
  logic id_fire;
  logic redir_misaligned;

  // Acks that arrive while no request is outstanding (e.g. after a reset
  // abandoned one) are ignored.
  assign ack_live         = bus.imem_ack & imem_req_q;
  // A request is still outstanding after this edge: its address must hold.
  assign bus_busy         = imem_req_q & ~bus.imem_ack;
  assign id_fire          = id_valid_q & bus.id_ready;
  assign redir_misaligned = (bus.redir_pc & ALIGN_MASK) != '0;

  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d         = state_q;
    pc_d            = pc_q;
    kill_d          = kill_q;
    skid_valid_d    = skid_valid_q;
    skid_inst_d     = skid_inst_q;
    skid_pc_d       = skid_pc_q;
    id_valid_d      = id_valid_q;
    id_inst_d       = id_inst_q;
    id_pc_d         = id_pc_q;
    id_misaligned_d = id_misaligned_q;

    if (id_fire) id_valid_d = 1'b0;

    // The killed request has completed; its data is simply dropped.
    if (ack_live && kill_q) kill_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pc_enable && !skid_valid_q) state_d = ST_REQ;
      end

      ST_REQ: begin
        if (ack_live && !kill_q) begin
          pc_d = req_addr_q + INC;
          if (!id_valid_q || bus.id_ready) begin
            id_valid_d      = 1'b1;
            id_inst_d       = bus.imem_rdata;
            id_pc_d         = req_addr_q;
            id_misaligned_d = 1'b0;
            state_d         = pc_enable ? ST_REQ : ST_IDLE;
          end else begin
            // Decode is stalled with a full IF/ID: park the response.
            skid_valid_d = 1'b1;
            skid_inst_d  = bus.imem_rdata;
            skid_pc_d    = req_addr_q;
            state_d      = ST_SKID;
          end
        end else if (ack_live) begin
          // Killed response arrived: restart at the (redirected) pc.
          state_d = pc_enable ? ST_REQ : ST_IDLE;
        end
      end

      ST_SKID: begin
        if (bus.id_ready) begin
          id_valid_d      = 1'b1;
          id_inst_d       = skid_inst_q;
          id_pc_d         = skid_pc_q;
          id_misaligned_d = 1'b0;
          skid_valid_d    = 1'b0;
          state_d         = pc_enable ? ST_REQ : ST_IDLE;
        end
      end

      ST_HALT: begin
        // Wait for an aligned redirect; the trap entry drains via id_fire.
      end

      default: state_d = ST_IDLE;
    endcase

    // Redirect overrides everything decided above.
    if (bus.redir_valid) begin
      pc_d            = bus.redir_pc;
      skid_valid_d    = 1'b0;
      id_valid_d      = 1'b0;
      id_misaligned_d = 1'b0;
      // An unacked request must finish at its old address; a same-cycle
      // ack is discarded, so nothing is left to kill.
      kill_d          = bus_busy;
      if (redir_misaligned) begin
        id_valid_d      = 1'b1;
        id_misaligned_d = 1'b1;
        id_inst_d       = NOP;
        id_pc_d         = bus.redir_pc;
        state_d         = ST_HALT;
      end else begin
        state_d = pc_enable ? ST_REQ : ST_IDLE;
      end
    end
  end

  // The address register tracks pc whenever the bus is free, so a new
  // request always starts at the current pc and imem_addr never moves while
  // a request is outstanding.
  assign req_addr_d = bus_busy ? req_addr_q : pc_d;
  // A killed request keeps imem_req high until its ack, whatever the state.
  assign imem_req_d = (state_d == ST_REQ) || kill_d;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge pc_reset_n) begin
    if (!pc_reset_n) begin
      state_q         <= ST_IDLE;
      pc_q            <= RESET_PC;
      req_addr_q      <= RESET_PC;
      imem_req_q      <= 1'b0;
      kill_q          <= 1'b0;
      skid_valid_q    <= 1'b0;
      skid_inst_q     <= NOP;
      skid_pc_q       <= '0;
      id_valid_q      <= 1'b0;
      id_inst_q       <= NOP;
      id_pc_q         <= '0;
      id_misaligned_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      req_addr_q      <= req_addr_d;
      imem_req_q      <= imem_req_d;
      kill_q          <= kill_d;
      skid_valid_q    <= skid_valid_d;
      skid_inst_q     <= skid_inst_d;
      skid_pc_q       <= skid_pc_d;
      id_valid_q      <= id_valid_d;
      id_inst_q       <= id_inst_d;
      id_pc_q         <= id_pc_d;
      id_misaligned_q <= id_misaligned_d;
    end
  end

  assign bus.imem_req      = imem_req_q;
  assign bus.imem_addr     = req_addr_q;
  assign bus.id_valid      = id_valid_q;
  assign bus.id_inst       = id_inst_q;
  assign bus.id_pc         = id_pc_q;
  assign bus.id_pc_next    = id_pc_q + INC;
  assign bus.id_misaligned = id_misaligned_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_unit
//   Directed bench for if_fetch_unit (XLEN=16, RESET_PC=0x100, 4-byte insts).
//   Memory returns {16'hC0DE, addr} for every fetch.
// ----------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam int XLEN = 16;

  logic clk;
  logic pc_reset_n;
  logic pc_enable;

  int checks = 0;
  int errors = 0;

  if_fetch_unit_if #(.XLEN(XLEN)) bus ();

  if_fetch_unit #(
    .XLEN      (XLEN),
    .RESET_PC  (16'h0100),
    .INST_BYTES(4)
  ) dut (
    .clk       (clk),
    .pc_reset_n(pc_reset_n),
    .pc_enable (pc_enable),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory response for the coming edge: ack the current request if en=1.
  task automatic mem(input bit en);
    bus.imem_ack   = en & bus.imem_req;
    bus.imem_rdata = {16'hC0DE, bus.imem_addr};
  endtask

  task automatic redir(input bit v, input logic [15:0] target);
    bus.redir_valid = v;
    bus.redir_pc    = target;
  endtask

  initial begin
    pc_reset_n     = 1'b0;
    pc_enable      = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    bus.id_ready   = 1'b1;
    redir(1'b0, 16'h0000);

    // ---- reset values ----
    #12;
    check("rst_imem_req",   32'(bus.imem_req),      32'h0);
    check("rst_imem_addr",  32'(bus.imem_addr),     32'h0100);
    check("rst_id_valid",   32'(bus.id_valid),      32'h0);
    check("rst_id_inst",    bus.id_inst,            32'h0000_0013);
    check("rst_id_pc",      32'(bus.id_pc),         32'h0);
    check("rst_id_pc_next", 32'(bus.id_pc_next),    32'h0004);
    check("rst_id_mis",     32'(bus.id_misaligned), 32'h0);

    // ---- 1: straight-line fetch, zero-wait memory ----
    pc_reset_n = 1'b1;
    pc_enable  = 1'b1;
    tick();
    check("t1_req_rise", 32'(bus.imem_req),  32'h1);
    check("t1_addr0",    32'(bus.imem_addr), 32'h0100);
    mem(1);
    tick();
    check("t1_valid0",   32'(bus.id_valid),   32'h1);
    check("t1_inst0",    bus.id_inst,         32'hC0DE_0100);
    check("t1_pc0",      32'(bus.id_pc),      32'h0100);
    check("t1_pcn0",     32'(bus.id_pc_next), 32'h0104);
    check("t1_addr1",    32'(bus.imem_addr),  32'h0104);
    mem(1);
    tick();
    check("t1_pc1",      32'(bus.id_pc),      32'h0104);
    check("t1_pcn1",     32'(bus.id_pc_next), 32'h0108);
    check("t1_addr2",    32'(bus.imem_addr),  32'h0108);
    mem(1);
    tick();
    check("t1_pc2",      32'(bus.id_pc),      32'h0108);
    check("t1_inst2",    bus.id_inst,         32'hC0DE_0108);
    check("t1_addr3",    32'(bus.imem_addr),  32'h010C);

    // ---- 2: stall with skid ----
    bus.id_ready = 1'b0;
    mem(1);                                    // 0x10C lands in the skid
    tick();
    check("t2_req_drop", 32'(bus.imem_req), 32'h0);
    check("t2_hold_pc0", 32'(bus.id_pc),    32'h0108);
    check("t2_hold_v0",  32'(bus.id_valid), 32'h1);
    mem(1);
    tick();
    check("t2_req_off1", 32'(bus.imem_req), 32'h0);
    check("t2_hold_pc1", 32'(bus.id_pc),    32'h0108);
    mem(1);
    tick();
    check("t2_hold_pc2", 32'(bus.id_pc),    32'h0108);
    bus.id_ready = 1'b1;
    mem(1);
    tick();
    check("t2_skid_pc",   32'(bus.id_pc),     32'h010C);
    check("t2_skid_inst", bus.id_inst,        32'hC0DE_010C);
    check("t2_req_back",  32'(bus.imem_req),  32'h1);
    check("t2_addr_back", 32'(bus.imem_addr), 32'h0110);
    mem(1);
    tick();
    check("t2_next_pc",   32'(bus.id_pc),     32'h0110);
    check("t2_next_addr", 32'(bus.imem_addr), 32'h0114);

    // ---- 4: redirect coincident with ack ----
    redir(1'b1, 16'h0080);
    mem(1);                                    // ack of 0x114 is dropped
    tick();
    check("t4_valid_drop", 32'(bus.id_valid),  32'h0);
    check("t4_addr",       32'(bus.imem_addr), 32'h0080);
    check("t4_req",        32'(bus.imem_req),  32'h1);
    redir(1'b0, 16'h0000);
    mem(1);
    tick();
    check("t4_pc",         32'(bus.id_pc),     32'h0080);
    check("t4_inst",       bus.id_inst,        32'hC0DE_0080);

    // ---- 3: redirect during pending request ----
    redir(1'b1, 16'h0200);
    mem(1);                                    // ack 0x84, go to 0x200
    tick();
    check("t3_addr_start", 32'(bus.imem_addr), 32'h0200);
    redir(1'b0, 16'h0000);
    mem(0);
    tick();
    check("t3_addr_c0", 32'(bus.imem_addr), 32'h0200);
    redir(1'b1, 16'h0400);
    mem(0);
    tick();
    check("t3_addr_c1",  32'(bus.imem_addr), 32'h0200);
    check("t3_req_c1",   32'(bus.imem_req),  32'h1);
    check("t3_valid_c1", 32'(bus.id_valid),  32'h0);
    redir(1'b0, 16'h0000);
    mem(0);
    tick();
    check("t3_addr_c2", 32'(bus.imem_addr), 32'h0200);
    mem(1);                                    // killed ack of 0x200
    tick();
    check("t3_dropped", 32'(bus.id_valid),  32'h0);
    check("t3_new_req", 32'(bus.imem_req),  32'h1);
    check("t3_new_addr",32'(bus.imem_addr), 32'h0400);
    mem(1);
    tick();
    check("t3_pc",   32'(bus.id_pc),     32'h0400);
    check("t3_inst", bus.id_inst,        32'hC0DE_0400);
    check("t3_addr", 32'(bus.imem_addr), 32'h0404);

    // ---- 5: misaligned redirect (0x404 still pending) ----
    redir(1'b1, 16'h0302);
    mem(0);
    tick();
    check("t5_valid", 32'(bus.id_valid),      32'h1);
    check("t5_mis",   32'(bus.id_misaligned), 32'h1);
    check("t5_inst",  bus.id_inst,            32'h0000_0013);
    check("t5_pc",    32'(bus.id_pc),         32'h0302);
    check("t5_pcn",   32'(bus.id_pc_next),    32'h0306);
    check("t5_pend",  32'(bus.imem_addr),     32'h0404);
    redir(1'b0, 16'h0000);
    bus.id_ready = 1'b0;
    mem(1);                                    // pending request completes
    tick();
    check("t5_req_off", 32'(bus.imem_req),      32'h0);
    check("t5_held_v",  32'(bus.id_valid),      32'h1);
    check("t5_held_m",  32'(bus.id_misaligned), 32'h1);
    check("t5_held_pc", 32'(bus.id_pc),         32'h0302);
    bus.id_ready = 1'b1;
    mem(1);
    tick();
    check("t5_taken",   32'(bus.id_valid), 32'h0);
    check("t5_halt0",   32'(bus.imem_req), 32'h0);
    mem(1);
    tick();
    check("t5_halt1",   32'(bus.imem_req), 32'h0);
    redir(1'b1, 16'h0300);
    mem(1);
    tick();
    check("t5_resume_req",  32'(bus.imem_req),  32'h1);
    check("t5_resume_addr", 32'(bus.imem_addr), 32'h0300);
    redir(1'b0, 16'h0000);
    mem(1);
    tick();
    check("t5_res_pc",   32'(bus.id_pc),         32'h0300);
    check("t5_res_inst", bus.id_inst,            32'hC0DE_0300);
    check("t5_res_mis",  32'(bus.id_misaligned), 32'h0);

    // ---- 6: wrap-around and asynchronous reset ----
    redir(1'b1, 16'hFFFC);
    mem(1);
    tick();
    check("t6_addr_top", 32'(bus.imem_addr), 32'hFFFC);
    redir(1'b0, 16'h0000);
    mem(1);
    tick();
    check("t6_pc_top",  32'(bus.id_pc),      32'hFFFC);
    check("t6_pcn_wrap",32'(bus.id_pc_next), 32'h0000);
    check("t6_wrap",    32'(bus.imem_addr),  32'h0000);
    check("t6_req_on",  32'(bus.imem_req),   32'h1);
    mem(0);
    #2;
    pc_reset_n = 1'b0;                         // between clock edges
    #1;
    check("t6_async_req",   32'(bus.imem_req),  32'h0);
    check("t6_async_valid", 32'(bus.id_valid),  32'h0);
    check("t6_async_addr",  32'(bus.imem_addr), 32'h0100);
    pc_enable = 1'b0;
    tick();
    pc_reset_n   = 1'b1;
    bus.imem_ack = 1'b1;                       // stray ack after reset
    tick();
    check("t6_stray_valid", 32'(bus.id_valid), 32'h0);
    check("t6_stray_req",   32'(bus.imem_req), 32'h0);
    bus.imem_ack = 1'b0;
    pc_enable    = 1'b1;
    tick();
    check("t6_restart_req",  32'(bus.imem_req),  32'h1);
    check("t6_restart_addr", 32'(bus.imem_addr), 32'h0100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
